// File: rtl/axis_merge_arbiter.sv
// Round-robin merge of S_COUNT AXI-Stream sources into one registered output stream.
// Per-source end markers are absorbed and replaced by one merged marker when all participants finish.
module axis_merge_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT-1:0]            ien,
    input  logic                          merge_enable,
    input  logic [S_COUNT-1:0]            single_mask,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          merge_done
);

    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    logic [S_COUNT-1:0]    part_mask;
    logic [S_COUNT-1:0]    done_seen;
    logic [S_COUNT-1:0]    req;
    logic [S_COUNT-1:0]    grant;
    logic [IDX_W-1:0]      last_g;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand;
    logic                  found;
    logic                  load;
    logic                  flush;
    logic                  accept;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        return IDX_W'(sum % S_COUNT);
    endfunction

    assign part_mask = ien & (merge_enable ? {S_COUNT{1'b1}} : single_mask);
    assign req       = s_axis_tvalid & part_mask & ~done_seen;
    assign load      = !m_axis_tvalid || m_axis_tready;
    assign flush     = (part_mask != '0) && ((done_seen & part_mask) == part_mask);

    // Cyclic search starting just after the last granted source.
    always_comb begin
        grant     = '0;
        grant_idx = last_g;
        cand      = last_g;
        found     = 1'b0;
        for (int unsigned k = 1; k <= S_COUNT; k++) begin
            cand = wrap_idx(last_g, k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Ready is gated by reset so no source sees a handshake while rst_n is low.
    assign s_axis_tready = grant & {S_COUNT{load && !flush && rst_n}};
    assign accept        = |s_axis_tready;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant[i]) begin
                sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = s_axis_tlast[i];
            end
        end
    end

    assign merge_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            done_seen     <= '0;
            last_g        <= IDX_W'(S_COUNT - 1);
        end else begin
            if (load) begin
                if (flush) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= '1;
                    m_axis_tlast  <= 1'b1;
                end else if (accept && !sel_last) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= sel_data;
                    m_axis_tlast  <= 1'b0;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            // Markers only record completion; their data never reaches the output.
            if (load && flush) begin
                done_seen <= '0;
            end else if (accept && sel_last) begin
                done_seen <= done_seen | grant;
            end
            if (accept) begin
                last_g <= grant_idx;
            end
        end
    end

endmodule
